// File: rtl/lc3_stage_sequencer.sv
// lc3_stage_sequencer: LC-3 FETCH/DECODE/EXECUTE/WRITEBACK stage register with memory stall, retire count and hang detect.
// Optional single-step parking (STEP/HALTED) is built when LC3_SINGLE_STEP_EN is defined.
module lc3_stage_sequencer #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             run_i,
  input  logic             mem_access_i,
  input  logic             mem_ready_i,
  input  logic             next_stage_le_i,
  input  logic [1:0]       next_stage_i,
`ifdef LC3_SINGLE_STEP_EN
  input  logic             step_i,
  output logic             halted_o,
`endif
  output logic [1:0]       stage_o,
  output logic             stall_o,
  output logic             instr_done_o,
  output logic [CNT_W-1:0] instr_count_o,
  output logic             timeout_o
);
  typedef enum logic [1:0] {
    DECODE    = 2'b00,
    EXECUTE   = 2'b01,
    WRITEBACK = 2'b10,
    FETCH     = 2'b11
  } stage_t;
  stage_t            stage_q, stage_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              done_q, timeout_q, timeout_d;
  logic              advance, retire, halted;
`ifdef LC3_SINGLE_STEP_EN
  logic              halted_q, halted_d;
  assign halted   = halted_q;
  assign halted_o = halted_q;
  // A retire parks the sequencer; STEP only matters while parked
  assign halted_d = retire | (halted_q & ~step_i);
`else
  assign halted = 1'b0;
`endif
  always_comb begin
    stall_o   = mem_access_i & ~mem_ready_i & (stage_q == FETCH | stage_q == WRITEBACK);
    advance   = run_i & ~stall_o & ~timeout_q & ~halted;
    stage_d   = advance ? (next_stage_le_i ? stage_t'(next_stage_i) : stage_t'(stage_q + 2'd1)) : stage_q;
    retire    = advance & (stage_q == WRITEBACK | stage_q == EXECUTE) & (stage_d == FETCH | stage_d == DECODE);
    wait_d    = advance ? '0 : (run_i & stall_o & (wait_q != '1)) ? wait_q + 1'b1 : wait_q;
    timeout_d = timeout_q | (run_i & stall_o & (wait_q == WAIT_W'(MAX_WAIT)));
    count_d   = count_q + CNT_W'(retire);
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stage_q   <= FETCH;
      wait_q    <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
      done_q    <= retire;
      timeout_q <= timeout_d;
    end
  end
`ifdef LC3_SINGLE_STEP_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) halted_q <= 1'b1;
    else          halted_q <= halted_d;
  end
`endif
  assign stage_o       = stage_q;
  assign instr_done_o  = done_q;
  assign instr_count_o = count_q;
  assign timeout_o     = timeout_q;
endmodule

// File: tb/tb_lc3_stage_sequencer.sv
// tb_lc3_stage_sequencer: directed and random stimulus against a stage-position reference model.
module tb_lc3_stage_sequencer;
`ifdef LC3_SINGLE_STEP_EN
  localparam int CW = 2;
  localparam bit STEP_EN = 1'b1;
`else
  localparam int CW = 16;
  localparam bit STEP_EN = 1'b0;
`endif
  localparam int MAXW = 15;
  logic clk = 1'b0, rst_n = 1'b0;
  logic run = 1'b0, ma = 1'b0, mr = 1'b0, le = 1'b0, step = 1'b0;
  logic [1:0] ns = 2'b00;
  logic [1:0] stage;
  logic stall, done, tout, halted;
  logic [CW-1:0] count;
  int errors = 0, checks = 0;
  lc3_stage_sequencer #(.CNT_W(CW), .MAX_WAIT(MAXW), .WAIT_W(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .run_i(run), .mem_access_i(ma), .mem_ready_i(mr),
    .next_stage_le_i(le), .next_stage_i(ns),
`ifdef LC3_SINGLE_STEP_EN
    .step_i(step), .halted_o(halted),
`endif
    .stage_o(stage), .stall_o(stall), .instr_done_o(done), .instr_count_o(count), .timeout_o(tout)
  );
`ifndef LC3_SINGLE_STEP_EN
  assign halted = 1'b0;
`endif
  always #5 clk = ~clk;
  // Model keeps the stage as a position in program order: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 WRITEBACK
  logic [1:0] code [4] = '{2'b11, 2'b00, 2'b01, 2'b10};
  int pos, m_cnt, m_wait;
  bit m_to, m_done, m_halt;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int pos_of(input logic [1:0] c);
    for (int i = 0; i < 4; i++) if (code[i] == c) return i;
    return 0;
  endfunction
  function automatic bit m_stall();
    return ma && !mr && (pos == 0 || pos == 3);
  endfunction
  task automatic model_reset();
    pos = 0; m_cnt = 0; m_wait = 0; m_to = 0; m_done = 0; m_halt = STEP_EN;
  endtask
  // Called at a negedge with inputs already applied; returns at the following negedge
  task automatic tick();
    bit st, go, ret;
    int np;
    st = m_stall();
    #1 chk("stall", stall, st);
    go = run && !st && !m_to && !m_halt;
    np = go ? (le ? pos_of(ns) : (pos + 1) % 4) : pos;
    ret = go && (pos >= 2) && (np <= 1);
    if (go) m_wait = 0;
    else if (run && st) begin
      if (m_wait == MAXW) m_to = 1;
      if (m_wait < 15) m_wait++;
    end
    if (STEP_EN) m_halt = ret ? 1'b1 : (step ? 1'b0 : m_halt);
    pos = np;
    m_done = ret;
    m_cnt = (m_cnt + (ret ? 1 : 0)) % (1 << CW);
    @(posedge clk);
    #1;
    chk("stage", stage, code[pos]);
    chk("done", done, m_done);
    chk("count", count, m_cnt);
    chk("timeout", tout, m_to);
    chk("halted", halted, m_halt);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_stage", stage, 3);
    chk("rst_count", count, 0);
    chk("rst_timeout", tout, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    run = 1; ma = 1; mr = 1; le = 0;
    repeat (6) tick();
    do_reset();
    repeat (12) tick();
`ifndef LC3_SINGLE_STEP_EN
    chk("seq12_count", count, 3);
    do_reset();
    mr = 0;
    repeat (3) tick();
    chk("stall_hold", stage, 3);
    mr = 1;
    tick();
    chk("stall_release", stage, 0);
    do_reset();
    mr = 0;
    repeat (15) tick();
    chk("pre_timeout", tout, 0);
    tick();
    chk("timeout_set", tout, 1);
    mr = 1;
    repeat (3) tick();
    chk("timeout_frozen", stage, 3);
    do_reset();
    mr = 1;
    repeat (2) tick();
    le = 1; ns = 2'b00;
    tick();
    chk("skip_stage", stage, 0);
    chk("skip_done", done, 1);
    chk("skip_count", count, 1);
    le = 0;
    repeat (4) tick();
`else
    chk("parked", stage, 3);
    for (int n = 0; n < 4; n++) begin
      step = 1; tick();
      step = 0; repeat (5) tick();
      chk("step_halted", halted, 1);
      if (n == 1) chk("two_steps_count", count, 2);
    end
    chk("wrap_count", count, 0);
    do_reset();
`endif
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      run  = ($urandom_range(0, 9) < 8);
      ma   = $urandom_range(0, 1);
      mr   = ($urandom_range(0, 9) < 7);
      le   = ($urandom_range(0, 4) == 0);
      ns   = 2'($urandom_range(0, 3));
      step = STEP_EN && ($urandom_range(0, 2) == 0);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
